// File: rtl/snn_synapse_sum42.sv
// 42-synapse PSP front end with balanced-tree membrane summation and threshold gate.
// Optional macro SUM_PIPE_EN registers the adder output (one extra cycle on o_sv/o_neuronout).
module snn_synapse_sum42 #(
    parameter int p_width = 8,
    parameter int p_shift = 8,
    parameter int p_decay = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [42:1]                   i_event,
    input  logic [42*p_width-1:0]         i_weight,
    input  logic [p_width+p_shift+6-1:0]  i_threshold,
    output logic [p_width+p_shift+6-1:0]  o_sv,
    output logic [42:1]                   o_sync,
    output logic [p_width+p_shift+6-1:0]  o_neuronout
);

    localparam int PW = p_width + p_shift;
    localparam int SW = PW + 6;

    logic [SW-1:0] w_l0 [0:63];
    logic [SW-1:0] w_l1 [0:31];
    logic [SW-1:0] w_l2 [0:15];
    logic [SW-1:0] w_l3 [0:7];
    logic [SW-1:0] w_l4 [0:3];
    logic [SW-1:0] w_l5 [0:1];
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_sv;

    genvar g;
    generate
        for (g = 1; g <= 42; g++) begin : g_syn
            logic          r_eq;
            logic          r_sync;
            logic [PW-1:0] r_psp;
            logic          w_edge;
            logic [PW-1:0] w_dec;

            assign w_edge = i_event[g] & ~r_eq;
            assign w_dec  = r_psp >> p_decay;

            // A fresh edge always wins over decay; the minimum step of 1 guarantees the PSP drains to 0.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_eq   <= 1'b0;
                    r_sync <= 1'b0;
                    r_psp  <= '0;
                end else begin
                    r_eq   <= i_event[g];
                    r_sync <= w_edge;
                    if (w_edge) begin
                        r_psp <= {i_weight[g*p_width-1 -: p_width], {p_shift{1'b0}}};
                    end else if (r_psp != '0) begin
                        if (w_dec != '0) begin
                            r_psp <= r_psp - w_dec;
                        end else begin
                            r_psp <= r_psp - PW'(1);
                        end
                    end
                end
            end

            assign o_sync[g]  = r_sync;
            assign w_l0[g-1]  = {{6{1'b0}}, r_psp};
        end

        // Pad the 42 operands to 64 so the tree is a clean power of two.
        for (g = 42; g < 64; g++) begin : g_pad
            assign w_l0[g] = '0;
        end

        for (g = 0; g < 32; g++) begin : g_t1
            assign w_l1[g] = w_l0[2*g] + w_l0[2*g+1];
        end
        for (g = 0; g < 16; g++) begin : g_t2
            assign w_l2[g] = w_l1[2*g] + w_l1[2*g+1];
        end
        for (g = 0; g < 8; g++) begin : g_t3
            assign w_l3[g] = w_l2[2*g] + w_l2[2*g+1];
        end
        for (g = 0; g < 4; g++) begin : g_t4
            assign w_l4[g] = w_l3[2*g] + w_l3[2*g+1];
        end
        for (g = 0; g < 2; g++) begin : g_t5
            assign w_l5[g] = w_l4[2*g] + w_l4[2*g+1];
        end
    endgenerate

    assign w_sum = w_l5[0] + w_l5[1];

`ifdef SUM_PIPE_EN
    logic [SW-1:0] r_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    assign w_sv = r_sum;
`else
    assign w_sv = w_sum;
`endif

    assign o_sv        = w_sv;
    assign o_neuronout = (w_sv >= i_threshold) ? w_sv : '0;

endmodule

// File: tb/tb_snn_synapse_sum42.sv
// Directed self-checking bench for snn_synapse_sum42 at default parameters (combinational adder build).
module tb_snn_synapse_sum42;

    localparam int W  = 8;
    localparam int SW = 22;

    logic            clk;
    logic            rst_n;
    logic [42:1]     ev;
    logic [42*W-1:0] wt;
    logic [SW-1:0]   thr;
    logic [SW-1:0]   sv;
    logic [42:1]     sync;
    logic [SW-1:0]   nout;

    int n_vec;
    int n_err;

    snn_synapse_sum42 dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_event     (ev),
        .i_weight    (wt),
        .i_threshold (thr),
        .o_sv        (sv),
        .o_sync      (sync),
        .o_neuronout (nout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_w(input int idx, input logic [W-1:0] val);
        wt[idx*W-1 -: W] = val;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ev    = '0;
        wt    = '0;
        thr   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ev    = '1;
        wt    = '1;
        thr   = '0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sv !== 22'd0) begin
            n_err++; $display("FAIL reset_sv got %0d want 0", sv);
        end
        n_vec++;
        if (sync !== 42'd0) begin
            n_err++; $display("FAIL reset_sync got %h want 0", sync);
        end
        n_vec++;
        if (nout !== 22'd0) begin
            n_err++; $display("FAIL reset_nout got %0d want 0", nout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (sync !== {42{1'b1}}) begin
            n_err++; $display("FAIL release_sync got %h want all ones", sync);
        end
        n_vec++;
        if (sv !== 22'd2741760) begin
            n_err++; $display("FAIL release_sv got %0d want 2741760", sv);
        end
        n_vec++;
        if (nout !== 22'd2741760) begin
            n_err++; $display("FAIL release_nout got %0d want 2741760", nout);
        end
        // events still high: no second pulse, each PSP 65280 -> 61200
        @(negedge clk);
        n_vec++;
        if (sync !== 42'd0) begin
            n_err++; $display("FAIL release_held_sync got %h want 0", sync);
        end
        n_vec++;
        if (sv !== 22'd2570400) begin
            n_err++; $display("FAIL release_decay_sv got %0d want 2570400", sv);
        end
    endtask

    task automatic test_single_decay();
        logic [SW-1:0] e;
        do_reset();
        set_w(1, 8'h10);
        ev[1] = 1'b1;
        @(negedge clk);
        ev[1] = 1'b0;
        n_vec++;
        if (sync !== 42'h1) begin
            n_err++; $display("FAIL single_sync got %h want 1", sync);
        end
        n_vec++;
        if (sv !== 22'd4096) begin
            n_err++; $display("FAIL single_load got %0d want 4096", sv);
        end
        @(negedge clk);
        n_vec++;
        if (sv !== 22'd3840) begin
            n_err++; $display("FAIL single_d1 got %0d want 3840", sv);
        end
        @(negedge clk);
        n_vec++;
        if (sv !== 22'd3600) begin
            n_err++; $display("FAIL single_d2 got %0d want 3600", sv);
        end
        e = 22'd3600;
        for (int c = 0; c < 200; c++) begin
            if (e != 0) e = ((e >> 4) != 0) ? e - (e >> 4) : e - 1;
            @(negedge clk);
            n_vec++;
            if (sv !== e) begin
                n_err++; $display("FAIL single_tail step %0d got %0d want %0d", c, sv, e);
            end
        end
        n_vec++;
        if (sv !== 22'd0) begin
            n_err++; $display("FAIL single_final got %0d want 0", sv);
        end
    endtask

    task automatic test_held();
        int pulses;
        do_reset();
        set_w(5, 8'h20);
        ev[5] = 1'b1;
        pulses = 0;
        @(negedge clk);
        if (sync[5]) pulses++;
        n_vec++;
        if (sv !== 22'd8192) begin
            n_err++; $display("FAIL held_load got %0d want 8192", sv);
        end
        // later weight changes must not touch the loaded PSP
        set_w(5, 8'hFF);
        @(negedge clk);
        if (sync[5]) pulses++;
        n_vec++;
        if (sv !== 22'd7680) begin
            n_err++; $display("FAIL held_d1 got %0d want 7680", sv);
        end
        @(negedge clk);
        if (sync[5]) pulses++;
        n_vec++;
        if (sv !== 22'd7200) begin
            n_err++; $display("FAIL held_d2 got %0d want 7200", sv);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sync[5]) pulses++;
        end
        ev[5] = 1'b0;
        n_vec++;
        if (pulses !== 1) begin
            n_err++; $display("FAIL held_pulses got %0d want 1", pulses);
        end
        n_vec++;
        if (!(sv < 22'd7200 && sv != 22'd0)) begin
            n_err++; $display("FAIL held_noreload got %0d want 0<sv<7200", sv);
        end
    endtask

    task automatic test_full_sum();
        do_reset();
        wt  = '1;
        thr = 22'd2741761;
        ev  = '1;
        @(negedge clk);
        ev = '0;
        n_vec++;
        if (sv !== 22'd2741760) begin
            n_err++; $display("FAIL full_sv got %0d want 2741760", sv);
        end
        n_vec++;
        if (nout !== 22'd0) begin
            n_err++; $display("FAIL full_below got %0d want 0", nout);
        end
        thr = 22'd2741760;
        #1;
        n_vec++;
        if (nout !== 22'd2741760) begin
            n_err++; $display("FAIL full_equal got %0d want 2741760", nout);
        end
    endtask

    task automatic test_threshold();
        do_reset();
        set_w(2, 8'h10);
        thr   = 22'd4097;
        ev[2] = 1'b1;
        @(negedge clk);
        ev[2] = 1'b0;
        n_vec++;
        if (sync !== 42'h2) begin
            n_err++; $display("FAIL thr_sync got %h want 2", sync);
        end
        n_vec++;
        if (nout !== 22'd0) begin
            n_err++; $display("FAIL thr_4097 got %0d want 0", nout);
        end
        thr = 22'd4096;
        #1;
        n_vec++;
        if (nout !== 22'd4096) begin
            n_err++; $display("FAIL thr_4096 got %0d want 4096", nout);
        end
    endtask

    task automatic test_zero_weight();
        do_reset();
        set_w(4, 8'h00);
        ev[4] = 1'b1;
        @(negedge clk);
        ev[4] = 1'b0;
        n_vec++;
        if (sync !== 42'h8) begin
            n_err++; $display("FAIL zero_sync got %h want 8", sync);
        end
        n_vec++;
        if (sv !== 22'd0) begin
            n_err++; $display("FAIL zero_sv got %0d want 0", sv);
        end
    endtask

    task automatic test_reload_reset();
        do_reset();
        set_w(3, 8'h10);
        ev[3] = 1'b1;
        @(negedge clk);
        ev[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sv !== 22'd3375) begin
            n_err++; $display("FAIL reload_pre got %0d want 3375", sv);
        end
        set_w(3, 8'h20);
        ev[3] = 1'b1;
        @(negedge clk);
        n_vec++;
        if (sync !== 42'h4) begin
            n_err++; $display("FAIL reload_sync got %h want 4", sync);
        end
        n_vec++;
        if (sv !== 22'd8192) begin
            n_err++; $display("FAIL reload_sv got %0d want 8192", sv);
        end
        @(negedge clk);
        n_vec++;
        if (sv !== 22'd7680) begin
            n_err++; $display("FAIL reload_d1 got %0d want 7680", sv);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sv !== 22'd0) begin
            n_err++; $display("FAIL midreset_sv got %0d want 0", sv);
        end
        n_vec++;
        if (sync !== 42'd0) begin
            n_err++; $display("FAIL midreset_sync got %h want 0", sync);
        end
        ev[3] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (sv !== 22'd0) begin
            n_err++; $display("FAIL post_reset_sv got %0d want 0", sv);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ev    = '0;
        wt    = '0;
        thr   = '0;
        test_reset();
        test_single_decay();
        test_held();
        test_full_sum();
        test_threshold();
        test_zero_weight();
        test_reload_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
